// File: rtl/ifu_fetch_if.sv
// Instruction-memory read channel between the fetch unit (master) and instruction memory (slave).
// Handshake: a beat moves on a rising edge where valid and ready are both high; valid never waits on ready.
interface ifu_fetch_if;
  logic        imem_arvalid;
  logic [31:0] imem_araddr;
  logic        imem_arready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [1:0]  imem_rresp;
  logic        imem_rready;

  modport master (
    output imem_arvalid, imem_araddr, imem_rready,
    input  imem_arready, imem_rvalid, imem_rdata, imem_rresp
  );

  modport slave (
    input  imem_arvalid, imem_araddr, imem_rready,
    output imem_arready, imem_rvalid, imem_rdata, imem_rresp
  );
endinterface

// File: rtl/ifu_fetch.sv
// Multicycle RV32 instruction fetch: holds the PC, reads one instruction per retire over
// the imem channel and offers it to decode; every output comes straight from a register.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic               clk,
  input  logic               rst,
  ifu_fetch_if.master        imem,
  output logic [31:0]        real_ins,
  output logic [31:0]        pc,
  output logic               ifu_valid,
  input  logic               idu_ready,
  input  logic               pc_update,
  input  logic [31:0]        next_pc,
  output logic               fetch_err,
  output logic [31:0]        fetch_cnt,
  output logic [2:0]         state
);

  typedef enum logic [2:0] {
    BOOT = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3,
    EXEC = 3'd4,
    ERR  = 3'd5
  } state_t;

  state_t st;
  logic   arvalid;
  logic   rready;
  logic   next_bad;

  assign imem.imem_arvalid = arvalid;
  assign imem.imem_araddr  = pc;
  assign imem.imem_rready  = rready;
  assign state             = st;
  assign next_bad          = (next_pc[1:0] != 2'b00);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st        <= BOOT;
      pc        <= RESET_PC;
      real_ins  <= 32'd0;
      fetch_cnt <= 32'd0;
      fetch_err <= 1'b0;
      arvalid   <= 1'b0;
      rready    <= 1'b0;
      ifu_valid <= 1'b0;
    end else begin
      case (st)
        BOOT: begin
          if (pc[1:0] != 2'b00) begin
            fetch_err <= 1'b1;
            st        <= ERR;
          end else begin
            arvalid <= 1'b1;
            st      <= REQ;
          end
        end

        REQ: begin
          if (imem.imem_arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            st      <= WAIT;
          end
        end

        WAIT: begin
          if (imem.imem_rvalid) begin
            rready <= 1'b0;
            if (imem.imem_rresp == 2'b00) begin
              real_ins  <= imem.imem_rdata;
              fetch_cnt <= fetch_cnt + 32'd1;
              ifu_valid <= 1'b1;
              st        <= HOLD;
            end else begin
              fetch_err <= 1'b1;
              st        <= ERR;
            end
          end
        end

        HOLD: begin
          if (idu_ready) begin
            ifu_valid <= 1'b0;
            // A retire coincident with the transfer skips EXEC and refetches at once.
            if (pc_update) begin
              pc <= next_pc;
              if (next_bad) begin
                fetch_err <= 1'b1;
                st        <= ERR;
              end else begin
                arvalid <= 1'b1;
                st      <= REQ;
              end
            end else begin
              st <= EXEC;
            end
          end
        end

        EXEC: begin
          if (pc_update) begin
            pc <= next_pc;
            if (next_bad) begin
              fetch_err <= 1'b1;
              st        <= ERR;
            end else begin
              arvalid <= 1'b1;
              st      <= REQ;
            end
          end
        end

        ERR: begin
          arvalid   <= 1'b0;
          rready    <= 1'b0;
          ifu_valid <= 1'b0;
          fetch_err <= 1'b1;
        end

        default: begin
          arvalid   <= 1'b0;
          rready    <= 1'b0;
          ifu_valid <= 1'b0;
          fetch_err <= 1'b1;
          st        <= ERR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: boot, backpressure, retire loop, error paths, async reset
// and counter wrap, with a transfer scoreboard fed from the expected-instruction queue.
module tb_ifu_fetch;

  localparam logic [2:0] S_BOOT = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_HOLD = 3'd3;
  localparam logic [2:0] S_EXEC = 3'd4;
  localparam logic [2:0] S_ERR  = 3'd5;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        idu_ready = 1'b0;
  logic        pc_update = 1'b0;
  logic [31:0] next_pc = 32'd0;
  logic [31:0] real_ins;
  logic [31:0] pc;
  logic [31:0] fetch_cnt;
  logic        ifu_valid;
  logic        fetch_err;
  logic [2:0]  state;

  int n_cmp  = 0;
  int n_bad  = 0;
  int n_xfer = 0;
  int x0;
  logic [31:0] exp_q[$];

  ifu_fetch_if imem ();

  ifu_fetch #(.RESET_PC(32'h8000_0000)) dut (
    .clk       (clk),
    .rst       (rst),
    .imem      (imem),
    .real_ins  (real_ins),
    .pc        (pc),
    .ifu_valid (ifu_valid),
    .idu_ready (idu_ready),
    .pc_update (pc_update),
    .next_pc   (next_pc),
    .fetch_err (fetch_err),
    .fetch_cnt (fetch_cnt),
    .state     (state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mem(input logic ar, input logic rv, input logic [31:0] data, input logic [1:0] resp);
    imem.imem_arready = ar;
    imem.imem_rvalid  = rv;
    imem.imem_rdata   = data;
    imem.imem_rresp   = resp;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pc"},       pc,                      32'h8000_0000);
    chk({tag, "_ins"},      real_ins,                32'd0);
    chk({tag, "_cnt"},      fetch_cnt,               32'd0);
    chk({tag, "_err"},      32'(fetch_err),          32'd0);
    chk({tag, "_arvalid"},  32'(imem.imem_arvalid),  32'd0);
    chk({tag, "_rready"},   32'(imem.imem_rready),   32'd0);
    chk({tag, "_ifuvalid"}, 32'(ifu_valid),          32'd0);
    chk({tag, "_state"},    32'(state),              32'(S_BOOT));
  endtask

  // reset, release, and take the always-ready memory through one fetch into HOLD
  task automatic do_boot(input string tag);
    rst = 1'b0;
    mem(1'b1, 1'b1, 32'h0000_0013, 2'b00);
    repeat (2) tick();
    rst = 1'b1;
    exp_q.push_back(32'h0000_0013);
    repeat (3) tick();
    chk({tag, "_state"}, 32'(state), 32'(S_HOLD));
    chk({tag, "_ins"},   real_ins,   32'h0000_0013);
    mem(1'b0, 1'b0, 32'd0, 2'b00);
  endtask

  // scoreboard: a transfer completes at the next rising edge
  always @(negedge clk) begin
    if (rst && ifu_valid && idu_ready) begin
      n_xfer++;
      chk("xfer_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) chk("xfer_ins", real_ins, exp_q.pop_front());
    end
  end

  initial begin
    mem(1'b1, 1'b1, 32'h0000_0013, 2'b00);

    // reset / boot
    repeat (3) tick();
    chk_reset_vals("rst");
    rst = 1'b1;
    exp_q.push_back(32'h0000_0013);
    tick();
    chk("boot_c1_arvalid", 32'(imem.imem_arvalid), 32'd1);
    chk("boot_c1_araddr",  imem.imem_araddr,       32'h8000_0000);
    chk("boot_c1_state",   32'(state),             32'(S_REQ));
    tick();
    chk("boot_c2_arvalid", 32'(imem.imem_arvalid), 32'd0);
    chk("boot_c2_rready",  32'(imem.imem_rready),  32'd1);
    tick();
    chk("boot_c3_valid",   32'(ifu_valid), 32'd1);
    chk("boot_c3_ins",     real_ins,       32'h0000_0013);
    chk("boot_c3_cnt",     fetch_cnt,      32'd1);
    chk("boot_c3_pc",      pc,             32'h8000_0000);
    mem(1'b0, 1'b0, 32'd0, 2'b00);

    // retire loop: transfer, then pc_update two cycles later
    idu_ready = 1'b1;
    tick();
    idu_ready = 1'b0;
    chk("loop_valid_drop", 32'(ifu_valid), 32'd0);
    chk("loop_exec",       32'(state),     32'(S_EXEC));
    tick();
    chk("loop_exec_idle",  32'(imem.imem_arvalid), 32'd0);
    pc_update = 1'b1;
    next_pc   = 32'h8000_0004;
    tick();
    pc_update = 1'b0;
    chk("loop_state",   32'(state),            32'(S_REQ));
    chk("loop_araddr",  imem.imem_araddr,      32'h8000_0004);
    chk("loop_arvalid", 32'(imem.imem_arvalid), 32'd1);

    // backpressure: arready held off 3 cycles
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_arvalid_hold", 32'(imem.imem_arvalid), 32'd1);
      chk("bp_araddr_hold",  imem.imem_araddr,       32'h8000_0004);
    end
    mem(1'b1, 1'b0, 32'd0, 2'b00);
    tick();
    mem(1'b0, 1'b0, 32'd0, 2'b00);
    chk("bp_wait",   32'(state),            32'(S_WAIT));
    chk("bp_rready", 32'(imem.imem_rready), 32'd1);
    pc_update = 1'b1;
    next_pc   = 32'h8000_0100;
    tick();
    pc_update = 1'b0;
    chk("wait_pcupd_ignored", pc,         32'h8000_0004);
    tick();
    chk("bp_rvalid_wait",     32'(state), 32'(S_WAIT));
    mem(1'b0, 1'b1, 32'h0050_0093, 2'b00);
    exp_q.push_back(32'h0050_0093);
    tick();
    mem(1'b0, 1'b0, 32'd0, 2'b00);
    chk("bp_hold", 32'(state), 32'(S_HOLD));
    chk("bp_ins",  real_ins,   32'h0050_0093);
    chk("bp_cnt",  fetch_cnt,  32'd2);
    x0 = n_xfer;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_valid_stable", 32'(ifu_valid), 32'd1);
      chk("bp_ins_stable",   real_ins,       32'h0050_0093);
      chk("bp_pc_stable",    pc,             32'h8000_0004);
    end
    // transfer coincident with retire goes straight to REQ
    idu_ready = 1'b1;
    pc_update = 1'b1;
    next_pc   = 32'h8000_0008;
    tick();
    idu_ready = 1'b0;
    pc_update = 1'b0;
    chk("bp_one_xfer",   32'(n_xfer - x0), 32'd1);
    chk("direct_state",  32'(state),       32'(S_REQ));
    chk("direct_araddr", imem.imem_araddr, 32'h8000_0008);
    chk("direct_valid",  32'(ifu_valid),   32'd0);

    // error response
    mem(1'b1, 1'b0, 32'd0, 2'b00);
    tick();
    mem(1'b0, 1'b1, 32'hdead_beef, 2'b10);
    tick();
    mem(1'b0, 1'b0, 32'd0, 2'b00);
    chk("rresp_err",    32'(fetch_err),        32'd1);
    chk("rresp_state",  32'(state),            32'(S_ERR));
    chk("rresp_ins",    real_ins,              32'h0050_0093);
    chk("rresp_cnt",    fetch_cnt,             32'd2);
    chk("rresp_rready", 32'(imem.imem_rready), 32'd0);
    next_pc = 32'h8000_0010;
    for (int i = 0; i < 10; i++) begin
      pc_update = ~pc_update;
      tick();
      chk("err_arvalid_low", 32'(imem.imem_arvalid), 32'd0);
      chk("err_sticky",      32'(fetch_err),         32'd1);
    end
    pc_update = 1'b0;

    // new reset clears the error, then a misaligned retire target
    rst = 1'b0;
    #1;
    chk("reclear_err",   32'(fetch_err), 32'd0);
    chk("reclear_state", 32'(state),     32'(S_BOOT));
    do_boot("reboot1");
    idu_ready = 1'b1;
    pc_update = 1'b1;
    next_pc   = 32'h8000_0006;
    tick();
    idu_ready = 1'b0;
    pc_update = 1'b0;
    chk("misalign_err",     32'(fetch_err),         32'd1);
    chk("misalign_state",   32'(state),             32'(S_ERR));
    chk("misalign_arvalid", 32'(imem.imem_arvalid), 32'd0);

    // async reset in the middle of WAIT
    do_boot("reboot2");
    idu_ready = 1'b1;
    pc_update = 1'b1;
    next_pc   = 32'h8000_0004;
    tick();
    idu_ready = 1'b0;
    pc_update = 1'b0;
    mem(1'b1, 1'b0, 32'd0, 2'b00);
    tick();
    mem(1'b0, 1'b0, 32'd0, 2'b00);
    chk("midwait_state", 32'(state), 32'(S_WAIT));
    chk("midwait_pc",    pc,         32'h8000_0004);
    #3;
    rst = 1'b0;
    mem(1'b0, 1'b1, 32'h1111_1111, 2'b00);
    #1;
    chk_reset_vals("async");
    repeat (2) tick();
    rst = 1'b1;
    tick();
    chk("post_rst_state",  32'(state),            32'(S_REQ));
    chk("post_rst_araddr", imem.imem_araddr,      32'h8000_0000);
    chk("post_rst_rready", 32'(imem.imem_rready), 32'd0);
    tick();
    chk("post_rst_ignore", fetch_cnt,  32'd0);
    chk("post_rst_req",    32'(state), 32'(S_REQ));
    mem(1'b1, 1'b1, 32'h0000_0013, 2'b00);
    exp_q.push_back(32'h0000_0013);
    repeat (2) tick();
    mem(1'b0, 1'b0, 32'd0, 2'b00);
    chk("refetch_ins", real_ins,  32'h0000_0013);
    chk("refetch_cnt", fetch_cnt, 32'd1);
    chk("refetch_pc",  pc,        32'h8000_0000);

    // counter wrap
    idu_ready = 1'b1;
    tick();
    idu_ready = 1'b0;
    force dut.fetch_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.fetch_cnt;
    #1;
    chk("wrap_preload", fetch_cnt, 32'hFFFF_FFFF);
    pc_update = 1'b1;
    next_pc   = 32'h8000_0040;
    tick();
    pc_update = 1'b0;
    mem(1'b1, 1'b0, 32'd0, 2'b00);
    tick();
    mem(1'b0, 1'b1, 32'h00a0_0113, 2'b00);
    exp_q.push_back(32'h00a0_0113);
    tick();
    mem(1'b0, 1'b0, 32'd0, 2'b00);
    chk("wrap_cnt", fetch_cnt, 32'd0);
    chk("wrap_ins", real_ins,  32'h00a0_0113);
    chk("wrap_pc",  pc,        32'h8000_0040);
    idu_ready = 1'b1;
    tick();
    idu_ready = 1'b0;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
